// File: rtl/mem_interface_pkg.sv
// Shared definitions for the LC-3 memory responder: word width and
// the access FSM state encoding.
package mem_interface_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_interface_register.sv
// Generic load-enabled register with asynchronous active-high clear,
// used for the LC-3 MAR.
module mem_interface_register #(
  parameter int W = 16
) (
  output logic [W-1:0] out,
  input  logic         clk,
  input  logic [W-1:0] in,
  input  logic         reset,
  input  logic         load
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out <= '0;
    else if (load)
      out <= in;
  end

endmodule

// File: rtl/mem_interface.sv
// LC-3 memory responder: MAR/MDR pair plus word-addressed RAM answered
// through a wait-state access FSM that pulses R once per completed access.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] Buss,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              selMDR,
  input  logic              memEN,
  input  logic              memWE,
  output logic [WORD_W-1:0] MAR,
  output logic [WORD_W-1:0] MDR,
  output logic              R
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_t           state, next_state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_lat;
  logic [WORD_W-1:0]    wdata_lat;
  logic                 we_lat;
  logic [WORD_W-1:0]    rd_data;
  logic                 start;
  logic                 unused_mar_hi;
  logic [WORD_W-1:0]    ram [2**ADDR_BITS];

  assign start   = (state == MEM_IDLE) && memEN;
  assign R       = (state == MEM_DONE);
  assign rd_data = ram[addr_lat];

  // Upper MAR bits alias onto the same RAM words.
  assign unused_mar_hi = ^MAR[WORD_W-1:ADDR_BITS];

  mem_interface_register #(.W(WORD_W)) mar_reg (
    .out   (MAR),
    .clk   (clk),
    .in    (Buss),
    .reset (reset),
    .load  (ldMAR)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= MEM_IDLE;
    else
      state <= next_state;
  end

  // Dropping memEN mid-access abandons it before any RAM side effect.
  always_comb begin
    next_state = state;
    case (state)
      MEM_IDLE: begin
        if (memEN)
          next_state = MEM_ACCESS;
      end
      MEM_ACCESS: begin
        if (!memEN)
          next_state = MEM_IDLE;
        else if (cnt == 4'd0)
          next_state = MEM_DONE;
      end
      MEM_DONE:  next_state = MEM_IDLE;
      default:   next_state = MEM_IDLE;
    endcase
  end

  // The in-flight access works from snapshots, so MAR/MDR stay free to reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      we_lat    <= 1'b0;
    end else if (start) begin
      cnt       <= WAIT_INIT;
      addr_lat  <= MAR[ADDR_BITS-1:0];
      wdata_lat <= MDR;
      we_lat    <= memWE;
    end else if (state == MEM_ACCESS && memEN && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == MEM_DONE && we_lat)
      ram[addr_lat] <= wdata_lat;
  end

  // RAM data is only taken on a completed read, never on a write or while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      MDR <= '0;
    else if (ldMDR && selMDR && R && !we_lat)
      MDR <= rd_data;
    else if (ldMDR && !selMDR)
      MDR <= Buss;
  end

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: an access-age reference model is
// compared every cycle, with directed scenarios pinned by literal values.
module tb_mem_interface;

  localparam int W  = 2;
  localparam int AB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Buss = '0;
  logic        ldMAR = 1'b0, ldMDR = 1'b0, selMDR = 1'b0;
  logic        memEN = 1'b0, memWE = 1'b0;
  logic [15:0] MAR, MDR;
  logic        R;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  mem_interface #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .Buss   (Buss),
    .ldMAR  (ldMAR),
    .ldMDR  (ldMDR),
    .selMDR (selMDR),
    .memEN  (memEN),
    .memWE  (memWE),
    .MAR    (MAR),
    .MDR    (MDR),
    .R      (R)
  );

  always #5 clk = ~clk;

  // Reference model: an access is tracked by its age in edges since it
  // started; it is complete (R high) once age reaches W+1.
  logic [15:0] m_mar = '0, m_mdr = '0;
  logic [15:0] m_ram [2**AB];
  int          age = -1;
  logic [AB-1:0] p_addr = '0;
  logic [15:0] p_wdata = '0;
  logic        p_we = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mar = '0;
      m_mdr = '0;
      age   = -1;
    end else begin
      logic cur_r;
      logic [15:0] old_mar, old_mdr;
      cur_r   = (age == W + 1);
      old_mar = m_mar;
      old_mdr = m_mdr;
      if (age < 0) begin
        if (memEN) begin
          age     = 0;
          p_addr  = old_mar[AB-1:0];
          p_wdata = old_mdr;
          p_we    = memWE;
        end
      end else if (age == W + 1) begin
        if (p_we) m_ram[p_addr] = p_wdata;
        age = -1;
      end else if (!memEN) begin
        age = -1;
      end else begin
        age = age + 1;
      end
      if (ldMDR && selMDR && cur_r && !p_we)
        m_mdr = m_ram[p_addr];
      else if (ldMDR && !selMDR)
        m_mdr = Buss;
      if (ldMAR) m_mar = Buss;
    end
  end

  function automatic void checkOutput(input string name, input logic [15:0] act,
                                      input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (started && !reset) begin
      checkOutput("R", {15'b0, R}, {15'b0, (age == W + 1)});
      checkOutput("MAR", MAR, m_mar);
      checkOutput("MDR", MDR, m_mdr);
    end
  end

  task automatic applyStimulus(input logic [15:0] bus, input logic ld_mar,
                               input logic ld_mdr, input logic sel_mdr,
                               input logic mem_en, input logic mem_we);
    @(negedge clk);
    Buss = bus; ldMAR = ld_mar; ldMDR = ld_mdr;
    selMDR = sel_mdr; memEN = mem_en; memWE = mem_we;
  endtask

  // Returns the number of negedges until R is seen (41 on timeout);
  // optionally reloads MAR with 0x0020 while the access is in flight.
  task automatic waitR(input bit chg_mar, output int n);
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (R) begin
        n = i;
        break;
      end
      if (chg_mar && i == 1) begin
        Buss = 16'h0020; ldMAR = 1'b1;
      end else begin
        ldMAR = 1'b0;
      end
    end
    memEN = 1'b0;
  endtask

  task automatic doAccess(input logic [15:0] addr, input logic we,
                          input logic [15:0] data, input bit chg_mar);
    int n;
    applyStimulus(addr, 1, 0, 0, 0, 0);
    if (we) applyStimulus(data, 0, 1, 0, 0, 0);
    applyStimulus(16'h0, 0, !we, !we, 1, we);
    waitR(chg_mar, n);
    checkOutput("latency", 16'(n - 1), 16'(W + 1));
    applyStimulus(16'h0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    #12;
    checkOutput("reset_MAR", MAR, 16'h0000);
    checkOutput("reset_MDR", MDR, 16'h0000);
    checkOutput("reset_R", {15'b0, R}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    started = 1'b1;

    for (int i = 0; i < 2**AB; i++)
      doAccess(16'(i), 1'b1, 16'($urandom), 1'b0);

    // Write then read back through the RAM path.
    doAccess(16'h0010, 1'b1, 16'hBEEF, 1'b0);
    doAccess(16'h0010, 1'b0, 16'h0, 1'b0);
    checkOutput("rd_beef", MDR, 16'hBEEF);

    // Upper MAR bits alias.
    doAccess(16'h0105, 1'b1, 16'h1234, 1'b0);
    doAccess(16'h0005, 1'b0, 16'h0, 1'b0);
    checkOutput("alias_rd", MDR, 16'h1234);

    // MAR reload during an access does not redirect it.
    doAccess(16'h0010, 1'b0, 16'h0, 1'b1);
    checkOutput("inflight_MDR", MDR, 16'hBEEF);
    checkOutput("inflight_MAR", MAR, 16'h0020);

    // Back-to-back reads with memEN held.
    doAccess(16'h0001, 1'b1, 16'hCAFE, 1'b0);
    doAccess(16'h0002, 1'b1, 16'hF00D, 1'b0);
    applyStimulus(16'h0001, 1, 0, 0, 0, 0);
    applyStimulus(16'h0, 0, 1, 1, 1, 0);
    waitR(1'b0, n);
    memEN = 1'b1; Buss = 16'h0002; ldMAR = 1'b1;
    @(negedge clk);
    ldMAR = 1'b0;
    checkOutput("b2b_first", MDR, 16'hCAFE);
    waitR(1'b0, n);
    checkOutput("b2b_gap", 16'(n + 1), 16'(W + 3));
    applyStimulus(16'h0, 0, 0, 0, 0, 0);
    checkOutput("b2b_second", MDR, 16'hF00D);

    // Aborted write: no R, RAM and MDR untouched.
    doAccess(16'h0030, 1'b1, 16'h1111, 1'b0);
    applyStimulus(16'h0030, 1, 0, 0, 0, 0);
    applyStimulus(16'h7777, 0, 1, 0, 0, 0);
    applyStimulus(16'h0, 0, 0, 0, 1, 1);
    repeat (6) applyStimulus(16'h0, 0, 1, 1, 0, 0);
    applyStimulus(16'h0, 0, 0, 0, 0, 0);
    checkOutput("abort_MDR", MDR, 16'h7777);
    doAccess(16'h0030, 1'b0, 16'h0, 1'b0);
    checkOutput("abort_ram", MDR, 16'h1111);

    // Asynchronous reset in the middle of a write access.
    doAccess(16'h0040, 1'b1, 16'h2222, 1'b0);
    applyStimulus(16'h0040, 1, 0, 0, 0, 0);
    applyStimulus(16'hDEAD, 0, 1, 0, 0, 0);
    applyStimulus(16'h0, 0, 0, 0, 1, 1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_MAR", MAR, 16'h0000);
    checkOutput("midrst_MDR", MDR, 16'h0000);
    checkOutput("midrst_R", {15'b0, R}, 16'h0000);
    memEN = 1'b0; memWE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    doAccess(16'h0040, 1'b0, 16'h0, 1'b0);
    checkOutput("midrst_ram", MDR, 16'h2222);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      Buss   = 16'($urandom);
      ldMAR  = ($urandom_range(0, 3) == 0);
      ldMDR  = $urandom_range(0, 1) == 1;
      selMDR = $urandom_range(0, 1) == 1;
      memEN  = ($urandom_range(0, 9) != 0);
      memWE  = $urandom_range(0, 1) == 1;
    end
    applyStimulus(16'h0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
